// File: rtl/scan_chain_driver_if.sv
// scan_chain_driver_if: pattern/response handshakes and scan pins for scan_chain_driver.
// rsp_par exists only when SCAN_RSP_PARITY_EN is defined.
interface scan_chain_driver_if #(parameter int CHAIN_LEN = 8);
    logic                 pat_valid;
    logic                 pat_ready;
    logic [CHAIN_LEN-1:0] pat_data;
    logic                 scan_se;
    logic                 scan_si;
    logic                 scan_so;
    logic                 cap_pulse;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CHAIN_LEN-1:0] rsp_data;
`ifdef SCAN_RSP_PARITY_EN
    logic                 rsp_par;
    modport master(input pat_valid, pat_data, scan_so, rsp_ready,
                   output pat_ready, scan_se, scan_si, cap_pulse, rsp_valid, rsp_data, rsp_par);
    modport slave(output pat_valid, pat_data, scan_so, rsp_ready,
                  input pat_ready, scan_se, scan_si, cap_pulse, rsp_valid, rsp_data, rsp_par);
`else
    modport master(input pat_valid, pat_data, scan_so, rsp_ready,
                   output pat_ready, scan_se, scan_si, cap_pulse, rsp_valid, rsp_data);
    modport slave(output pat_valid, pat_data, scan_so, rsp_ready,
                  input pat_ready, scan_se, scan_si, cap_pulse, rsp_valid, rsp_data);
`endif
endinterface

// File: rtl/scan_chain_driver.sv
// scan_chain_driver: loads a pattern into a scan chain, pulses capture, unloads the response.
// Optional serial response parity on rsp_par is enabled by defining SCAN_RSP_PARITY_EN.
module scan_chain_driver #(parameter int CHAIN_LEN = 8) (
    input logic clk,
    input logic rst,
    scan_chain_driver_if.master bus
);
    localparam int CW = $clog2(CHAIN_LEN) + 1;
    typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [CHAIN_LEN-1:0] pat_q, rsp_q;
    logic rsp_v;
    logic last;
    assign last = cnt == CW'(CHAIN_LEN - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        bus.pat_ready = 1'b0;
        bus.scan_se = 1'b0;
        bus.scan_si = 1'b0;
        bus.cap_pulse = 1'b0;
        case (state)
            IDLE: begin
                bus.pat_ready = 1'b1;
                if (bus.pat_valid) state_n = LOAD;
            end
            LOAD: begin
                bus.scan_se = 1'b1;
                bus.scan_si = pat_q[0];
                if (last) state_n = CAPTURE;
            end
            CAPTURE: begin
                bus.cap_pulse = 1'b1;
                state_n = UNLOAD;
            end
            UNLOAD: begin
                bus.scan_se = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: if (rsp_v && bus.rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // rsp_v rises one cycle after entering DONE, giving the fixed 2*CHAIN_LEN+2 latency
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            pat_q <= '0;
            rsp_q <= '0;
            rsp_v <= 1'b0;
        end else begin
            cnt <= (state == LOAD || state == UNLOAD) ? (last ? '0 : cnt + 1'b1) : '0;
            if (state == IDLE && bus.pat_valid) pat_q <= bus.pat_data;
            else if (state == LOAD) pat_q <= pat_q >> 1;
            if (state == UNLOAD) rsp_q <= {bus.scan_so, rsp_q[CHAIN_LEN-1:1]};
            rsp_v <= state == DONE && !(rsp_v && bus.rsp_ready);
        end
    assign bus.rsp_valid = rsp_v;
    assign bus.rsp_data = rsp_q;
`ifdef SCAN_RSP_PARITY_EN
    logic par;
    always_ff @(posedge clk or posedge rst)
        if (rst) par <= 1'b0;
        else if (state == IDLE && bus.pat_valid) par <= 1'b0;
        else if (state == UNLOAD) par <= par ^ bus.scan_so;
    assign bus.rsp_par = par;
`endif
endmodule

// File: tb/tb_scan_chain_driver.sv
// tb_scan_chain_driver: directed test of scan_chain_driver against a chain model and a
// phase-based reference model, for CHAIN_LEN=8 and CHAIN_LEN=2.
module tb_scan_chain_driver;
    localparam int N = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    scan_chain_driver_if #(.CHAIN_LEN(N)) b8();
    scan_chain_driver_if #(.CHAIN_LEN(2)) b2();
    scan_chain_driver #(.CHAIN_LEN(N)) dut8(.clk(clk), .rst(rst), .bus(b8.master));
    scan_chain_driver #(.CHAIN_LEN(2)) dut2(.clk(clk), .rst(rst), .bus(b2.master));
    int npass = 0;
    int ntot = 0;
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        ntot++;
        if (a === e) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    endtask
    // scan chains: cell 0 takes scan_si, last cell drives scan_so; capture is identity or inversion
    logic [N-1:0] ch8 = '0;
    logic [1:0] ch2 = '0;
    bit inv = 1'b0;
    always @(posedge clk)
        if (b8.scan_se) ch8 <= {ch8[N-2:0], b8.scan_si};
        else if (b8.cap_pulse) ch8 <= inv ? ~ch8 : ch8;
    always @(posedge clk)
        if (b2.scan_se) ch2 <= {ch2[0], b2.scan_si};
    assign b8.scan_so = ch8[N-1];
    assign b2.scan_so = ch2[1];
    // reference: ph = cycles since the pattern handshake edge
    bit busy = 1'b0;
    int ph = 0;
    logic [N-1:0] mp = '0, edata = '0;
    always @(posedge clk or posedge rst)
        if (rst) busy <= 1'b0;
        else if (!busy) begin
            if (b8.pat_valid) begin
                busy <= 1'b1;
                ph <= 0;
                mp <= b8.pat_data;
                edata <= inv ? ~b8.pat_data : b8.pat_data;
            end
        end else if (ph >= 2*N+2 && b8.rsp_ready) busy <= 1'b0;
        else ph <= ph + 1;
    always @(negedge clk) begin
        logic ev;
        ev = busy && ph >= 2*N+2;
        chk("se", b8.scan_se, busy && ph != N && ph <= 2*N);
        chk("si", b8.scan_si, (busy && ph < N) ? mp[ph] : 1'b0);
        chk("cap", b8.cap_pulse, busy && ph == N);
        chk("ready", b8.pat_ready, !busy);
        chk("valid", b8.rsp_valid, ev);
        if (ev) chk("data", b8.rsp_data, edata);
`ifdef SCAN_RSP_PARITY_EN
        if (ev) chk("par", b8.rsp_par, ^edata);
`endif
    end
    task automatic send8(input logic [7:0] d);
        b8.pat_valid = 1'b1;
        b8.pat_data = d;
        @(posedge clk);
        #1 b8.pat_valid = 1'b0;
    endtask
    task automatic run8(output int lat, output int se_n, output int cap_n);
        lat = 0; se_n = 0; cap_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b8.rsp_valid) break;
            se_n += int'(b8.scan_se);
            cap_n += int'(b8.cap_pulse);
            @(posedge clk);
            lat++;
        end
        chk("timeout8", b8.rsp_valid, 1);
    endtask
    task automatic accept8(input int hold);
        repeat (hold) @(posedge clk);
        @(posedge clk);
        #1 b8.rsp_ready = 1'b1;
        @(posedge clk);
        #1 b8.rsp_ready = 1'b0;
    endtask
    int lat, se_n, cap_n, vn;
    initial begin
        b8.pat_valid = 1'b0; b8.pat_data = '0; b8.rsp_ready = 1'b0;
        b2.pat_valid = 1'b0; b2.pat_data = '0; b2.rsp_ready = 1'b0;
        @(negedge clk);
        chk("rst_se", b8.scan_se, 0);
        chk("rst_valid", b8.rsp_valid, 0);
        chk("rst_data", b8.rsp_data, 0);
        chk("rst_cap", b8.cap_pulse, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", b8.pat_ready, 1);
        @(posedge clk);
        #1 send8(8'hA5);
        run8(lat, se_n, cap_n);
        chk("lat_a5", lat, 18);
        chk("se_cycles", se_n, 16);
        chk("cap_once", cap_n, 1);
        chk("data_a5", b8.rsp_data, 32'hA5);
        accept8(0);
        @(negedge clk);
        chk("idle_after_acc", b8.pat_ready, 1);
        @(posedge clk);
        #1 inv = 1'b1;
        send8(8'h0F);
        run8(lat, se_n, cap_n);
        chk("data_inv", b8.rsp_data, 32'hF0);
`ifdef SCAN_RSP_PARITY_EN
        chk("par_f0", b8.rsp_par, 0);
`endif
        repeat (20) @(negedge clk);
        chk("hold_data", b8.rsp_data, 32'hF0);
        chk("hold_se", b8.scan_se, 0);
        chk("hold_ready", b8.pat_ready, 0);
        chk("hold_valid", b8.rsp_valid, 1);
        @(posedge clk);
        #1 b8.rsp_ready = 1'b1;
        @(posedge clk);
        #1 b8.rsp_ready = 1'b0;
        @(negedge clk);
        chk("pulse_idle", b8.pat_ready, 1);
        chk("pulse_valid", b8.rsp_valid, 0);
        @(posedge clk);
        #1 inv = 1'b0;
        send8(8'h01);
        run8(lat, se_n, cap_n);
        chk("data_01", b8.rsp_data, 32'h01);
`ifdef SCAN_RSP_PARITY_EN
        chk("par_01", b8.rsp_par, 1);
`endif
        @(posedge clk);
        #1 b8.pat_valid = 1'b1; b8.pat_data = 8'h5A; b8.rsp_ready = 1'b1;
        @(posedge clk);
        #1 b8.rsp_ready = 1'b0;
        @(negedge clk);
        chk("b2b_idle", b8.pat_ready, 1);
        chk("b2b_not_loading", b8.scan_se, 0);
        @(posedge clk);
        #1 b8.pat_valid = 1'b0;
        @(negedge clk);
        chk("b2b_loading", b8.scan_se, 1);
        run8(lat, se_n, cap_n);
        chk("b2b_lat", lat, 17);
        chk("data_5a", b8.rsp_data, 32'h5A);
        accept8(0);
        send8(8'hC3);
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("abort_se", b8.scan_se, 0);
        chk("abort_valid", b8.rsp_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        vn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vn += int'(b8.rsp_valid);
        end
        chk("abort_no_valid", vn, 0);
        @(posedge clk);
        #1 send8(8'h3C);
        run8(lat, se_n, cap_n);
        chk("lat_3c", lat, 18);
        chk("data_3c", b8.rsp_data, 32'h3C);
        accept8(0);
        b2.pat_valid = 1'b1; b2.pat_data = 2'b10;
        @(posedge clk);
        #1 b2.pat_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b2.rsp_valid) break;
            @(posedge clk);
            lat++;
        end
        chk("timeout2", b2.rsp_valid, 1);
        chk("lat_n2", lat, 6);
        chk("data_n2", b2.rsp_data, 32'h2);
        @(posedge clk);
        #1 b2.rsp_ready = 1'b1;
        @(posedge clk);
        #1 b2.rsp_ready = 1'b0;
        @(negedge clk);
        chk("n2_idle", b2.pat_ready, 1);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/scan_chain_driver.md
SCAN_CHAIN_DRIVER -- requirements
Module: scan_chain_driver

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8, number of scan cells in the attached chain (legal range 2..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pat_valid  input  1  load pattern offered.
REQ-005 SHALL have port pat_ready  output  1  driver idle and accepting a pattern.
REQ-006 SHALL have port pat_data  input  CHAIN_LEN  pattern to shift into the chain.
REQ-007 SHALL have port scan_se  output  1  scan-enable to the chain's scan-enable flops.
REQ-008 SHALL have port scan_si  output  1  serial data into chain cell 0.
REQ-009 SHALL have port scan_so  input  1  serial data from last chain cell.
REQ-010 SHALL have port cap_pulse  output  1  one-cycle marker of the functional capture clock.
REQ-011 SHALL have port rsp_valid  output  1  unloaded response available.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port rsp_data  output  CHAIN_LEN  unloaded response vector.
REQ-014 SHALL have port rsp_par  output  1  response parity (present only per Configuration).

Function
REQ-015 SHALL implement states IDLE, LOAD, CAPTURE, UNLOAD, DONE.
REQ-016 SHALL assert pat_ready only in IDLE; handshake on pat_valid&&pat_ready registers pat_data and enters LOAD next cycle.
REQ-017 SHALL, in LOAD, hold scan_se=1 for exactly CHAIN_LEN cycles, driving scan_si=pat[k] in load cycle k (k=0..CHAIN_LEN-1, LSB first).
REQ-018 SHALL ignore scan_so during LOAD.
REQ-019 SHALL spend exactly one cycle in CAPTURE with scan_se=0, cap_pulse=1, scan_si=0.
REQ-020 SHALL, in UNLOAD, hold scan_se=1 for exactly CHAIN_LEN cycles, drive scan_si=0, and sample scan_so into rsp_data[k] at the end of unload cycle k.
REQ-021 SHALL enter DONE after the last unload cycle, asserting rsp_valid with rsp_data stable until rsp_valid&&rsp_ready.
REQ-022 SHALL return to IDLE the cycle after response acceptance; pat_valid in the DONE-accept cycle is not accepted (pat_ready=0).
REQ-023 SHALL give fixed latency: pattern handshake edge to rsp_valid high = 2*CHAIN_LEN+2 cycles.
REQ-024 SHALL keep scan_se=0 and cap_pulse=0 in IDLE and DONE.
REQ-025 SHALL use a shift counter of clog2(CHAIN_LEN)+1 bits, wrapping to 0 at each LOAD/UNLOAD exit; no off-by-one at CHAIN_LEN=2.
REQ-026 SHALL hold rsp_valid indefinitely if rsp_ready stays low, with no chain activity.

Reset
REQ-027 SHALL, while rst=1, force state IDLE, counter 0, pat_ready=1 after release, scan_se=0, scan_si=0, cap_pulse=0, rsp_valid=0, rsp_data=0, rsp_par=0.
REQ-028 SHALL abandon any in-progress LOAD/CAPTURE/UNLOAD on rst without emitting rsp_valid; scan_se drops asynchronously.

Configuration
REQ-029 SHALL gate rsp_par with macro SCAN_RSP_PARITY_EN: defined -> rsp_par = XOR of rsp_data, valid alongside rsp_valid, accumulated serially during UNLOAD; undefined -> port absent, no parity logic.

Verification
REQ-030 CHAIN_LEN=8, bench models 8-flop chain with identity capture, pat_data=8'hA5 -> rsp_data=8'hA5, rsp_valid 18 cycles after handshake, scan_se high 8+8 cycles, cap_pulse exactly once.
REQ-031 Capture model inverts every cell, pat_data=8'h0F -> rsp_data=8'hF0; with SCAN_RSP_PARITY_EN, rsp_par=0; pattern 8'h01 identity -> rsp_par=1.
REQ-032 rsp_ready held low 20 cycles after rsp_valid -> rsp_data unchanged, scan_se=0, pat_ready=0; rsp_ready pulse -> IDLE next cycle.
REQ-033 rst asserted in UNLOAD cycle 3 -> scan_se=0 immediately, no rsp_valid; next pattern 8'h3C completes correctly.
REQ-034 CHAIN_LEN=2, pat_data=2'b10 identity -> rsp_data=2'b10 after 6 cycles.
REQ-035 pat_valid held high through DONE-accept cycle -> second pattern accepted only in following IDLE cycle.
